// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared rs232 definitions for the transmitter and receiver
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rs232_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity: XOR over data and this bit is zero.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// rtl/rs232_baud_tick.sv - bit-period counter emitting a one-cycle bit_tick
module rs232_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic ARstN,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge ARstN) begin
        if (!ARstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - rs232 serial transmitter with one-entry holding register
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       ARstN,
    input  logic       en,
    input  logic       ParityCheck,
    input  logic       load,
    input  logic [7:0] d_in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       d_out
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    rs232_state_e state_q, state_d;
    logic [7:0]   hold_q, hold_d, shift_q, shift_d;
    logic         hold_full_q, hold_full_d;
    logic         par_q, par_d, pen_q, pen_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic         stop_cnt_q, stop_cnt_d;
    logic         line_q, line_d, busy_q, busy_d;
    logic         done_q, done_d, overrun_q, overrun_d;
    logic         transfer, bit_tick;

    // Counter is held at zero while idle so every frame starts on a full bit.
    rs232_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .ARstN    (ARstN),
        .clr      (state_q == ST_IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pen_d      = pen_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        transfer   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q && en) begin
                    transfer = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = pen_q ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        done_d = 1'b1;
                        if (hold_full_q && en) begin
                            transfer = 1'b1;
                            state_d  = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (transfer) begin
            shift_d = hold_q;
            par_d   = even_parity(hold_q);
            pen_d   = ParityCheck;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = load && hold_full_q;
        if (transfer) begin
            hold_full_d = 1'b0;
        end
        if (load && !hold_full_q) begin
            hold_d      = d_in;
            hold_full_d = 1'b1;
        end

        // Line level is derived from the next state so d_out is a plain flop.
        case (state_d)
            ST_START:  line_d = START_LEVEL;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge ARstN) begin
        if (!ARstN) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            pen_q       <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            line_q      <= IDLE_LEVEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            pen_q       <= pen_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ready   = !hold_full_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;
    assign d_out   = line_q;

endmodule
